layer_dispatch_ctrl: RTL

- Initiator-side controller for start/busy/done cost-model engines, with dfconv as the first client.
- Buffers layer shape descriptors pushed by the host/top-level in a small FIFO.
- On a run command, issues each descriptor to the engine in order and waits for done.
- Accumulates the engine's reported cycles_used into a run total and counts completed layers; a watchdog aborts a run if the engine hangs.

---
 rtl/layer_dispatch_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/layer_dispatch_ctrl.sv
// Layer dispatch controller: queues layer shape descriptors and issues them one at a
// time to a start/busy/done engine, totalling reported cycles with a hang watchdog.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for run; results of the last run stay visible
// S_ISSUE     | head descriptor ready, waiting for the engine to be free
// S_WAIT_DONE | engine working on the issued layer; watchdog counting
// S_FINISH    | run over (normal or aborted); all_done pulses next cycle
module layer_dispatch_ctrl #(
    parameter int          WIDTH       = 16,
    parameter int          ACC_WIDTH   = 32,
    parameter int          FIFO_DEPTH  = 8,
    parameter int unsigned WDOG_CYCLES = 1048575
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [WIDTH-1:0]     desc_rows,
    input  logic [WIDTH-1:0]     desc_cols,
    input  logic [WIDTH-1:0]     desc_in_ch,
    input  logic [WIDTH-1:0]     desc_out_ch,
    input  logic                 run,
    output logic                 eng_start,
    output logic [WIDTH-1:0]     eng_rows,
    output logic [WIDTH-1:0]     eng_cols,
    output logic [WIDTH-1:0]     eng_in_ch,
    output logic [WIDTH-1:0]     eng_out_ch,
    input  logic                 eng_busy,
    input  logic                 eng_done,
    input  logic [ACC_WIDTH-1:0] eng_cycles_used,
    output logic                 busy,
    output logic                 all_done,
    output logic [ACC_WIDTH-1:0] total_cycles,
    output logic [WIDTH-1:0]     layers_done,
    output logic                 timeout_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DESC_W = 4 * WIDTH;
    localparam int WD_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DESC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              ready_en;
    logic              push;
    logic [DESC_W-1:0] head;

    logic [WD_W-1:0]   wdog_cnt;
    logic              wdog_expired;

    logic              fire;
    logic              accept_run;
    logic              done_ok;
    logic              wdog_abort;
    logic [ACC_WIDTH:0] sum;

    // ready is held low until the first clock after reset release
    assign desc_ready   = ready_en && (fifo_cnt != CNT_W'(FIFO_DEPTH));
    assign push         = desc_valid && desc_ready;
    assign fifo_empty   = (fifo_cnt == '0);
    assign head         = mem[rd_ptr];
    assign wdog_expired = (WDOG_CYCLES != 0) && (wdog_cnt == '0);
    assign busy         = (state != S_IDLE);
    assign sum          = {1'b0, total_cycles} + {1'b0, eng_cycles_used};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = fifo_empty ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                if (!eng_busy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (eng_done)          state_nxt = fifo_empty ? S_FINISH : S_ISSUE;
                else if (wdog_expired) state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // output / strobe decode
    always_comb begin
        fire       = 1'b0;
        accept_run = 1'b0;
        done_ok    = 1'b0;
        wdog_abort = 1'b0;
        case (state)
            S_IDLE:  accept_run = run;
            S_ISSUE: fire       = !eng_busy;
            S_WAIT_DONE: begin
                if (eng_done)          done_ok    = 1'b1;
                else if (wdog_expired) wdog_abort = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {desc_rows, desc_cols, desc_in_ch, desc_out_ch};
    end

    // an abort flush keeps a descriptor pushed in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (wdog_abort) begin
            rd_ptr   <= wr_ptr;
            wr_ptr   <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            fifo_cnt <= push ? CNT_W'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, fire})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_start  <= 1'b0;
            eng_rows   <= '0;
            eng_cols   <= '0;
            eng_in_ch  <= '0;
            eng_out_ch <= '0;
        end else begin
            eng_start <= fire;
            if (fire) begin
                eng_rows   <= head[4*WIDTH-1 -: WIDTH];
                eng_cols   <= head[3*WIDTH-1 -: WIDTH];
                eng_in_ch  <= head[2*WIDTH-1 -: WIDTH];
                eng_out_ch <= head[WIDTH-1 -: WIDTH];
            end
        end
    end

    // watchdog down-counter: expires at zero on the WDOG_CYCLES-th waiting cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (fire) begin
            wdog_cnt <= WD_W'(WDOG_CYCLES - 1);
        end else if (state == S_WAIT_DONE && !eng_done && wdog_cnt != '0) begin
            wdog_cnt <= wdog_cnt - WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_done     <= 1'b0;
            total_cycles <= '0;
            layers_done  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            all_done <= (state == S_FINISH);
            if (accept_run) begin
                total_cycles <= '0;
                layers_done  <= '0;
                timeout_err  <= 1'b0;
            end else if (done_ok) begin
                total_cycles <= sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
                layers_done  <= layers_done + WIDTH'(1);
            end else if (wdog_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
